// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle for the bit-serial subtractor.
//   start, a, b, bin : request side, driven by the master
//   busy, done       : status, driven by the subtractor
//   diff, bout       : result, driven by the subtractor, held between completions
// WIDTH must match the WIDTH of the serial_sub instance attached to it.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor that time-shares one full-subtractor cell.
// Computes diff = (a - b - bin) mod 2^WIDTH and bout = (a < b + bin), LSB first,
// one bit per clock. A request is accepted in IDLE or DONE; the result and a
// one-cycle done pulse appear WIDTH edges after the accepting edge.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (aborts any operation in flight)
//   bus  - serial_sub_if slave: start/a/b/bin in, busy/done/diff/bout out
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    // Full-subtractor cell fed with the current LSBs and the stored borrow.
    logic             d_bit;
    logic             nb_bit;
    logic [WIDTH-1:0] r_shifted;

    assign d_bit     = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
    assign nb_bit    = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
    // Difference bits enter at the MSB, so after WIDTH shifts bit 0 sits at bit 0.
    assign r_shifted = {d_bit, r_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // DONE falls back to IDLE unless a back-to-back request arrives.
                state_d = IDLE;
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    brw_d   = bus.bin;
                    r_sr_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                r_sr_d = r_shifted;
                brw_d  = nb_bit;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = r_shifted;
                    bout_d  = nb_bit;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed checks of serial_sub at WIDTH=8 (latency, result,
// ignored start during RUN, back-to-back operation, async abort) plus an
// exhaustive sweep of a WIDTH=4 instance against (a - b - bin) mod 16.
module tb_serial_sub;
    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    serial_sub_if #(.WIDTH(8)) bus8 ();
    serial_sub_if #(.WIDTH(4)) bus4 ();

    serial_sub #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with the WIDTH=8 instance idle.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] ed, input logic eb);
        int busy_n;
        int done_at;
        bus8.start = 1'b1;
        bus8.a     = av;
        bus8.b     = bv;
        bus8.bin   = bi;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.bin   = 1'($urandom);
        busy_n  = 0;
        done_at = -1;
        for (int i = 1; i <= 20 && done_at < 0; i++) begin
            if (bus8.busy) busy_n++;
            @(posedge clk); #1;
            if (bus8.done) done_at = i;
        end
        check({tag, "_latency"}, done_at, 8);
        check({tag, "_busy_cycles"}, busy_n, 8);
        check({tag, "_diff"}, bus8.diff, ed);
        check({tag, "_bout"}, bus8.bout, eb);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, bus8.done, 0);
        $display("[TB] %s a=%h b=%h bin=%b -> diff=%h bout=%b", tag, av, bv, bi,
                 bus8.diff, bus8.bout);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        int done_at;
        int done_n;
        logic [3:0] ed;
        logic       eb;
        ed = 4'(av - bv - 4'(bi));
        eb = ({1'b0, av} < ({1'b0, bv} + 5'(bi)));
        bus4.start = 1'b1;
        bus4.a     = av;
        bus4.b     = bv;
        bus4.bin   = bi;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        done_at = -1;
        done_n  = 0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (bus4.done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = i;
                    check("w4_diff", bus4.diff, ed);
                    check("w4_bout", bus4.bout, eb);
                end
            end
        end
        check("w4_latency", done_at, 4);
        check("w4_done_count", done_n, 1);
        $display("[TB] w4 a=%h b=%h bin=%b -> diff=%h bout=%b", av, bv, bi, bus4.diff, bus4.bout);
    endtask

    initial begin
        int done_n;
        int t1;
        int t2;
        int low_n;

        n_tests = 0;
        n_fail  = 0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_diff", bus8.diff, 0);
        check("rst_bout", bus8.bout, 0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic operation and borrow boundaries.
        op8("sub_5a_23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        op8("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        op8("sub_10_10_b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
        op8("sub_80_7f_b", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

        // start pulsed during RUN cycles 2-5 must be ignored.
        bus8.start = 1'b1; bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.bin = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        done_n = 0;
        t1 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                done_n++;
                if (t1 < 0) t1 = i;
            end
            if (i == 1) begin
                bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'hFF; bus8.bin = 1'b0;
            end
            if (i == 5) bus8.start = 1'b0;
        end
        check("ignore_latency", t1, 8);
        check("ignore_done_count", done_n, 1);
        check("ignore_diff", bus8.diff, 8'hE1);
        check("ignore_bout", bus8.bout, 0);
        $display("[TB] ignore_start a=f0 b=0f -> diff=%h bout=%b dones=%0d", bus8.diff, bus8.bout, done_n);

        // Back-to-back with start held high.
        bus8.start = 1'b1; bus8.a = 8'h05; bus8.b = 8'h03; bus8.bin = 1'b0;
        @(posedge clk); #1;
        done_n = 0;
        t1 = -1;
        t2 = -1;
        low_n = 0;
        for (int i = 1; i <= 30 && done_n < 2; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                done_n++;
                if (done_n == 1) begin
                    t1 = i;
                    check("b2b_first_diff", bus8.diff, 8'h02);
                    check("b2b_first_bout", bus8.bout, 0);
                    bus8.a = 8'h03; bus8.b = 8'h05;
                end else begin
                    t2 = i;
                    check("b2b_second_diff", bus8.diff, 8'hFE);
                    check("b2b_second_bout", bus8.bout, 1);
                    bus8.start = 1'b0;
                end
            end
            if (done_n == 1 && !bus8.busy) low_n++;
        end
        bus8.start = 1'b0;
        check("b2b_first_latency", t1, 8);
        check("b2b_spacing", t2 - t1, 9);
        check("b2b_busy_low", low_n, 1);
        $display("[TB] back_to_back 05-03 then 03-05 -> spacing=%0d final diff=%h bout=%b",
                 t2 - t1, bus8.diff, bus8.bout);
        @(posedge clk); #1;

        // Asynchronous abort in RUN cycle 4.
        bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", bus8.busy, 0);
        check("abort_done", bus8.done, 0);
        check("abort_diff", bus8.diff, 0);
        check("abort_bout", bus8.bout, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        done_n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) done_n++;
        end
        check("abort_no_activity", done_n, 0);
        $display("[TB] abort mid-run -> diff=%h bout=%b", bus8.diff, bus8.bout);
        op8("after_abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0);

        // Exhaustive WIDTH=4 sweep.
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int bi = 0; bi < 2; bi++)
                    op4(4'(av), 4'(bv), 1'(bi));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
